// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared Y86-64 definitions used by the memory stage.
//   - icode constants (IHALT..IPOPQ), status codes (SAOK..SINS), RNONE
//   - FSM state type for mem_access
//   - decode helpers: is_write / is_read classify the data-memory access
//   - default values for MEM_BYTES and TIMEOUT_CYCLES
package mem_access_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;   // also CMOVXX
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [1:0] SAOK = 2'd0;
   localparam logic [1:0] SHLT = 2'd1;
   localparam logic [1:0] SADR = 2'd2;
   localparam logic [1:0] SINS = 2'd3;

   localparam logic [3:0] RNONE = 4'hF;

   localparam int MEM_BYTES_DEF      = 8192;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic is_write(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
   endfunction

   function automatic logic is_read(input logic [3:0] icode);
      return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: bus-request watchdog for the memory stage.
//   clk_i     in  clock
//   rst_n_i   in  synchronous reset, active low
//   start_i   in  request is being launched this cycle (counter clears)
//   active_i  in  request outstanding (FSM in REQ)
//   ack_i     in  bus ack this cycle (counter holds)
//   expired_o out request has waited TIMEOUT_CYCLES cycles without ack
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic start_i,
   input  logic active_i,
   input  logic ack_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q <= '0;
      end else if (active_i && !ack_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // The first REQ cycle sees count 0, so expiry on count T-1 gives T cycles of request.
   assign expired_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access.sv
// mem_access: Y86-64 memory stage.
// Accepts an executed instruction (valid/ready), performs its data-memory
// read or write over a req/ack bus, and presents valM, final stat and
// writeback controls to writeback (valid/ready).
// Ports:
//   clk_i, rst_n_i (sync, active low)
//   in_valid_i/in_ready_o, icode_i, stat_i, Cnd_i, valE_i, valA_i, valP_i, dstE_i, dstM_i
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_err_i, mem_rdata_i
//   out_valid_o/out_ready_i, icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o
// Optional macro MEM_TIMEOUT_EN: adds a watchdog that aborts a request with
// stat ADR after TIMEOUT_CYCLES cycles without ack.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [3:0]  icode_i,
   input  logic [1:0]  stat_i,
   input  logic        Cnd_i,
   input  logic [63:0] valE_i,
   input  logic [63:0] valA_i,
   input  logic [63:0] valP_i,
   input  logic [3:0]  dstE_i,
   input  logic [3:0]  dstM_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic        mem_err_i,
   input  logic [63:0] mem_rdata_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [3:0]  icode_o,
   output logic [1:0]  stat_o,
   output logic [63:0] valE_o,
   output logic [63:0] valM_o,
   output logic [3:0]  dstE_o,
   output logic [3:0]  dstM_o
);

   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

   state_e      state_q;
   logic        mem_req_q, mem_we_q, rd_q, out_valid_q;
   logic [63:0] mem_addr_q, mem_wdata_q, valE_q, valM_q;
   logic [3:0]  icode_q, dstE_q, dstM_q;
   logic [1:0]  stat_q;

   // Decode of the incoming instruction (used only on the accept edge)
   logic        wr_d, rd_d, acc_d, addr_ok_d, start_req;
   logic [63:0] addr_d, wdata_d;
   logic [3:0]  dstE_d;
   logic        expired;

   always_comb begin
      wr_d      = is_write(icode_i);
      rd_d      = is_read(icode_i);
      acc_d     = wr_d || rd_d;
      // Stack pops read at the old %rsp (valA); everything else addresses at valE
      addr_d    = ((icode_i == IPOPQ) || (icode_i == IRET)) ? valA_i : valE_i;
      wdata_d   = (icode_i == ICALL) ? valP_i : valA_i;
      addr_ok_d = (addr_d <= ADDR_MAX);
      // A not-taken conditional move writes nothing
      dstE_d    = ((icode_i == IRRMOVQ) && !Cnd_i) ? RNONE : dstE_i;
      start_req = (state_q == ST_IDLE) && in_valid_i && (stat_i == SAOK) && acc_d && addr_ok_d;
   end

`ifdef MEM_TIMEOUT_EN
   mem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .start_i   (start_req),
      .active_i  (state_q == ST_REQ),
      .ack_i     (mem_ack_i),
      .expired_o (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_q        <= 1'b0;
         out_valid_q <= 1'b0;
         icode_q     <= INOP;
         stat_q      <= SAOK;
         valE_q      <= '0;
         valM_q      <= '0;
         dstE_q      <= RNONE;
         dstM_q      <= RNONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i) begin
                  icode_q <= icode_i;
                  valE_q  <= valE_i;
                  valM_q  <= '0;
                  dstE_q  <= dstE_d;
                  dstM_q  <= dstM_i;
                  rd_q    <= rd_d;
                  if (start_req) begin
                     stat_q      <= SAOK;
                     state_q     <= ST_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= wr_d;
                     mem_addr_q  <= addr_d;
                     mem_wdata_q <= wdata_d;
                  end else begin
                     // Upstream fault wins over a range fault; no bus activity either way
                     if (stat_i != SAOK)  stat_q <= stat_i;
                     else if (acc_d)      stat_q <= SADR;
                     else                 stat_q <= SAOK;
                     state_q     <= ST_RESP;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               // Ack in the expiry cycle takes priority over the watchdog
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (mem_err_i) begin
                     stat_q <= SADR;
                     valM_q <= '0;
                  end else if (rd_q) begin
                     valM_q <= mem_rdata_i;
                  end
                  state_q     <= ST_RESP;
                  out_valid_q <= 1'b1;
               end else if (expired) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  stat_q      <= SADR;
                  valM_q      <= '0;
                  state_q     <= ST_RESP;
                  out_valid_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               mem_req_q   <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign out_valid_o = out_valid_q;
   assign icode_o     = icode_q;
   assign stat_o      = stat_q;
   assign valE_o      = valE_q;
   assign valM_o      = valM_q;
   assign dstE_o      = dstE_q;
   assign dstM_o      = dstM_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the Y86-64 core; the consumer side of the execute stage's valE/Cnd outputs.
- Accepts one executed instruction per valid/ready handshake and performs the data-memory read or write it needs over a multicycle req/ack bus.
- Presents valM, final stat and writeback controls to the writeback stage with a valid/ready handshake.

Parameters:
- MEM_BYTES, 8192, size of data address space in bytes; legal access when addr <= MEM_BYTES-8.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active low
- in_valid_i  in  1  execute-stage result valid
- in_ready_o  out  1  stage can accept
- icode_i  in  4  instruction code
- stat_i  in  2  upstream status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- Cnd_i  in  1  condition result from execute
- valE_i  in  64  ALU result
- valA_i  in  64  register operand A
- valP_i  in  64  next PC
- dstE_i  in  4  E destination register
- dstM_i  in  4  M destination register
- mem_req_o  out  1  bus request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  64  byte address
- mem_wdata_o  out  64  write data
- mem_ack_i  in  1  bus completion strobe (1 cycle)
- mem_err_i  in  1  bus error, sampled with ack
- mem_rdata_i  in  64  read data, valid with ack
- out_valid_o  out  1  result valid to writeback
- out_ready_i  in  1  writeback accepts
- icode_o  out  4  registered icode
- stat_o  out  2  final status
- valE_o  out  64  registered valE
- valM_o  out  64  memory read data, 0 if no read
- dstE_o  out  4  effective E destination; 0xF = none
- dstM_o  out  4  registered dstM

Behaviour:
- Reset state (clock edge with rst_n_i=0):
  - FSM goes to IDLE.
  - in_ready_o=1 (combinational from IDLE).
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - out_valid_o=0.
  - icode_o=1 (NOP), stat_o=0, valE_o=0, valM_o=0, dstE_o=0xF, dstM_o=0xF.
  - Reset during REQ abandons the request: mem_req_o is low after the edge, and a late mem_ack_i is ignored.
- FSM states: IDLE, REQ, RESP.
- in_ready_o = (state==IDLE).
- Accept occurs when IDLE and in_valid_i=1. All inputs are registered at the accept edge.
- Operation decode:
  - Write: RMMOVQ(4) addr=valE data=valA; PUSHQ(A) addr=valE data=valA; CALL(8) addr=valE data=valP.
  - Read: MRMOVQ(5) addr=valE; POPQ(B) addr=valA; RET(9) addr=valA.
  - All others: no access.
- Transitions from IDLE on accept:
  - stat_i!=AOK: go to RESP with stat_o=stat_i and no bus activity.
  - Access with addr > MEM_BYTES-8 (unsigned, 64-bit compare): go to RESP with stat_o=ADR and no bus activity.
  - Legal access: go to REQ, with mem_req_o=1 on the cycle after accept.
  - No access: go to RESP.
- REQ: mem_req/we/addr/wdata are held stable until mem_ack_i=1. At the ack edge:
  - Read: valM_o=mem_rdata_i.
  - mem_err_i=1: stat_o=ADR and valM_o=0.
  - Then go to RESP, with req deasserted in the same edge.
- RESP: out_valid_o=1 and all outputs are held stable until out_ready_i=1, then go to IDLE.
  - in_ready_o stays low in RESP, so there is no accept in the same cycle as the handoff.
- Latency:
  - No-access op: out_valid_o 1 cycle after accept.
  - Access op: out_valid_o 1 cycle after the ack cycle.
  - Peak throughput: 1 instruction per 2 cycles.
- dstE_o = 0xF when icode==CMOVQ(2) and Cnd_i==0; otherwise dstE_i.
- valM_o=0 for non-read ops and all faulting cases.
- stat_o priority: upstream non-AOK > address-range ADR > bus error ADR > AOK.
- mem_ack_i outside REQ is ignored.
- HLT passes through unchanged; the stage does not stall on it.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: drop mem_req_o, stat_o=ADR, valM_o=0, go to RESP.
  - An ack in the same cycle as expiry wins: normal completion.
- Undefined: REQ waits indefinitely for mem_ack_i; no counter logic.

Decomposition:
- Shared define header, alongside existing instruction/ALU codes: icode constants (IHALT..IPOPQ), stat codes (SAOK=0, SHLT=1, SADR=2, SINS=3), RNONE=4'hF.
- mem_access keeps the FSM and address/data muxing.
- Natural sub-module: mem_watchdog (counter + expiry flag), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- MRMOVQ, valE=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> req addr=0x100 we=0; out_valid 1 cycle after ack; valM_o=0xDEADBEEF, stat_o=AOK.
- CALL, valE=0x1F8, valP=0x40 -> mem_we_o=1, addr=0x1F8, wdata=0x40; valM_o=0.
- PUSHQ with valE=MEM_BYTES-7 -> no mem_req_o ever; stat_o=ADR one cycle after accept.
- OPQ, then CMOVQ with Cnd_i=0, dstE_i=3 -> each out_valid 1 cycle after accept, no bus activity; CMOVQ dstE_o=0xF. out_ready_i held 0 for 4 cycles -> outputs stable, in_ready_o=0 throughout.
- POPQ, valA=0x80, ack with mem_err_i=1 -> stat_o=ADR, valM_o=0. Separately, stat_i=INS on RMMOVQ -> no request; stat_o=INS.
- Reset asserted mid-REQ, then a stray ack -> mem_req_o=0 after reset edge, ack ignored, out_valid_o stays 0. With MEM_TIMEOUT_EN and no ack -> stat_o=ADR after TIMEOUT_CYCLES cycles of req.
